// File: rtl/pu_msp430_dac_pkg.sv
// Shared constants and types for the MSP430 serial DAC interface.
// Register offsets, status bit positions, FSM states and frame helper.
package pu_msp430_dac_pkg;

    localparam int FRAME_W = 16;
    localparam int DATA_W  = 12;

    localparam logic [2:0] DAC_VAL   = 3'h0;
    localparam logic [2:0] DAC_STAT  = 3'h2;
    localparam logic [2:0] DAC_CNTRL = 3'h4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_PEND = 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GUARD
    } dac_state_t;

    function automatic logic [FRAME_W-1:0] mk_frame(
        input logic [1:0]        pd,
        input logic [DATA_W-1:0] val
    );
        return {2'b00, pd, val};
    endfunction

endpackage

// File: rtl/pu_msp430_dac_clkdiv.sv
// Free-running sclk generator: half period is clkdiv+1 mclk cycles.
// Strobes mark the mclk cycle on which sclk is about to toggle.
module pu_msp430_dac_clkdiv (
    input  logic       mclk,
    input  logic       puc_rst,
    input  logic [7:0] clkdiv,
    input  logic       reload,
    output logic       sclk,
    output logic       sclk_rise,
    output logic       sclk_fall
);

    logic [7:0] cnt;
    logic       tick;

    // A reload restarts the half period, so it suppresses the toggle
    assign tick      = (cnt == clkdiv) && !reload;
    assign sclk_rise = tick && !sclk;
    assign sclk_fall = tick && sclk;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            cnt  <= 8'd0;
            sclk <= 1'b0;
        end else if (reload) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt  <= 8'd0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/pu_msp430_dac_spi_if.sv
// Peripheral-bus SPI master feeding a 12-bit serial DAC.
// Register file, one-deep pending buffer, frame FSM and shifter.
module pu_msp430_dac_spi_if
    import pu_msp430_dac_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0190,
    parameter int          DEC_WD    = 3
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        din,
    output logic        sclk,
    output logic        sync_n
);

    logic [DATA_W-1:0]  val_q;
    logic [1:0]         pd_q;
    logic [7:0]         clkdiv_q;
    logic               busy;
    logic               pend;
    dac_state_t         state;
    logic [FRAME_W-1:0] shreg;
    logic [3:0]         bitcnt;

    logic              reg_sel;
    logic [DEC_WD-1:0] reg_off;
    logic              wr_val;
    logic              wr_cntrl;
    logic              rd_en;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              start;
    logic              bits_unused;

    assign reg_sel  = per_en &&
                      (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_off  = {per_addr[DEC_WD-2:0], 1'b0};
    assign wr_val   = reg_sel && (reg_off == DAC_VAL) && (|per_we);
    assign wr_cntrl = reg_sel && (reg_off == DAC_CNTRL) && (|per_we);
    assign rd_en    = reg_sel && !(|per_we);

    assign bits_unused = ^{per_din[15:12], per_din[7:2], sclk_fall};

    pu_msp430_dac_clkdiv u_clkdiv (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .clkdiv    (clkdiv_q),
        .reload    (wr_cntrl && per_we[1]),
        .sclk      (sclk),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            val_q    <= '0;
            pd_q     <= 2'b00;
            clkdiv_q <= 8'd0;
        end else begin
            if (wr_val && per_we[0]) val_q[7:0]  <= per_din[7:0];
            if (wr_val && per_we[1]) val_q[11:8] <= per_din[11:8];
            if (wr_cntrl && per_we[0]) pd_q     <= per_din[1:0];
            if (wr_cntrl && per_we[1]) clkdiv_q <= per_din[15:8];
        end
    end

    // A new frame may start from IDLE or straight out of GUARD
    assign start = sclk_rise && pend && (state != SHIFT);

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= 4'd0;
            din    <= 1'b0;
            sync_n <= 1'b1;
            busy   <= 1'b0;
            pend   <= 1'b0;
        end else begin
            if (start) begin
                shreg  <= mk_frame(pd_q, val_q);
                din    <= 1'b0;
                din    <= mk_frame(pd_q, val_q) >> (FRAME_W - 1) != 0;
                bitcnt <= 4'd15;
                sync_n <= 1'b0;
                busy   <= 1'b1;
                pend   <= 1'b0;
                state  <= SHIFT;
            end else if (sclk_rise) begin
                unique case (state)
                    SHIFT: begin
                        if (bitcnt == 4'd0) begin
                            sync_n <= 1'b1;
                            din    <= 1'b0;
                            state  <= GUARD;
                        end else begin
                            bitcnt <= bitcnt - 4'd1;
                            din    <= shreg[FRAME_W-2];
                            shreg  <= {shreg[FRAME_W-2:0], 1'b0};
                        end
                    end
                    GUARD: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    IDLE: ;
                    default: state <= IDLE;
                endcase
            end
            // A write landing on a start cycle stays queued
            if (wr_val) pend <= 1'b1;
        end
    end

    always_comb begin
        per_dout = 16'h0000;
        if (rd_en) begin
            case (reg_off)
                DAC_VAL:   per_dout = {4'h0, val_q};
                DAC_STAT:  per_dout = {14'h0, pend, busy};
                DAC_CNTRL: per_dout = {clkdiv_q, 6'h00, pd_q};
                default:   per_dout = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_pu_msp430_dac_spi_if.sv
// Directed plus randomized bench for the serial DAC interface,
// with a behavioural DAC receiver and frame run-length monitors.
module tb_pu_msp430_dac_spi_if;

    localparam logic [14:0] BASE   = 15'h0190;
    localparam logic [2:0]  O_VAL  = 3'h0;
    localparam logic [2:0]  O_STAT = 3'h2;
    localparam logic [2:0]  O_CTL  = 3'h4;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic        din;
    logic        sclk;
    logic        sync_n;

    int n_cmp = 0;
    int n_err = 0;

    pu_msp430_dac_spi_if dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .per_addr (per_addr),
        .per_din  (per_din),
        .per_en   (per_en),
        .per_we   (per_we),
        .per_dout (per_dout),
        .din      (din),
        .sclk     (sclk),
        .sync_n   (sync_n)
    );

    always #5 mclk = ~mclk;

    // DAC receiver: shifts on sclk falls while sync_n low,
    // latches on the first fall with sync_n high after 16 bits
    logic [15:0] sr = 16'h0;
    int          nb = 0;
    logic [11:0] vout = 12'h0;
    logic [15:0] cap[$];

    always @(negedge sclk or posedge puc_rst) begin
        if (puc_rst) begin
            nb <= 0;
        end else if (sync_n === 1'b0) begin
            sr <= {sr[14:0], din};
            nb <= nb + 1;
        end else begin
            if (nb == 16) begin
                vout <= sr[11:0];
                cap.push_back(sr);
            end
            nb <= 0;
        end
    end

    int lo = 0, hi = 1000, last_low = 0, last_gap = 0;
    int shi = 0, last_shi = 0;

    always @(negedge mclk) begin
        if (puc_rst) begin
            lo <= 0;
            hi <= 1000;
        end else if (sync_n === 1'b0) begin
            if (lo == 0) last_gap <= hi;
            lo <= lo + 1;
        end else begin
            if (lo != 0) begin
                last_low <= lo;
                hi <= 1;
            end else begin
                hi <= hi + 1;
            end
            lo <= 0;
        end
        if (sclk === 1'b1) shi <= shi + 1;
        else if (shi != 0) begin
            last_shi <= shi;
            shi <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a write for one cycle starting at the current negedge
    task automatic wr_at(input logic [2:0] off, input logic [15:0] d,
                         input logic [1:0] we);
        per_addr = {BASE[14:3], off[2:1]};
        per_din  = d;
        per_we   = we;
        per_en   = 1'b1;
        @(negedge mclk);
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] d,
                      input logic [1:0] we);
        @(negedge mclk);
        wr_at(off, d, we);
    endtask

    task automatic rd(input logic [2:0] off, output logic [15:0] d);
        per_addr = {BASE[14:3], off[2:1]};
        per_we   = 2'b00;
        per_en   = 1'b1;
        #1;
        d = per_dout;
        per_en = 1'b0;
    endtask

    task automatic wait_frames(input int k, input string tag);
        int   target;
        logic got;
        target = cap.size() + k;
        for (int i = 0; i < 4000; i++) begin
            if (cap.size() >= target) break;
            @(negedge mclk);
        end
        got = (cap.size() >= target);
        chk({tag, "_timeout"}, {31'h0, got}, 32'h1);
    endtask

    initial begin
        logic [15:0] d;
        logic [1:0]  pd;
        logic [11:0] v;
        logic [7:0]  cd;
        int          base;
        int          bcyc;
        logic        seen;

        puc_rst  = 1'b1;
        per_addr = 14'h0;
        per_din  = 16'h0;
        per_en   = 1'b0;
        per_we   = 2'b00;
        repeat (3) @(negedge mclk);
        chk("rst_sclk", {31'h0, sclk}, 32'h0);
        chk("rst_sync_n", {31'h0, sync_n}, 32'h1);
        chk("rst_din", {31'h0, din}, 32'h0);
        chk("rst_dout_idle", {16'h0, per_dout}, 32'h0);
        puc_rst = 1'b0;
        @(negedge mclk);
        rd(O_VAL, d);  chk("rst_val", {16'h0, d}, 32'h0);
        rd(O_STAT, d); chk("rst_stat", {16'h0, d}, 32'h0);
        rd(O_CTL, d);  chk("rst_ctl", {16'h0, d}, 32'h0);

        // Reset in the middle of a frame
        wr(O_CTL, 16'h0001, 2'b11);
        wr(O_VAL, 16'h0123, 2'b11);
        for (int i = 0; i < 500 && nb < 5; i++) @(negedge mclk);
        chk("abort_reached", {31'h0, nb >= 5}, 32'h1);
        puc_rst = 1'b1;
        #1;
        chk("abort_sync_n", {31'h0, sync_n}, 32'h1);
        chk("abort_sclk", {31'h0, sclk}, 32'h0);
        chk("abort_din", {31'h0, din}, 32'h0);
        @(negedge mclk);
        puc_rst = 1'b0;
        rd(O_STAT, d); chk("abort_stat", {16'h0, d}, 32'h0);
        rd(O_VAL, d);  chk("abort_val", {16'h0, d}, 32'h0);
        rd(O_CTL, d);  chk("abort_ctl", {16'h0, d}, 32'h0);
        repeat (80) @(negedge mclk);
        chk("abort_vout", {20'h0, vout}, 32'h0);
        chk("abort_nframes", cap.size(), 32'h0);

        // Single frame at full speed, BUSY polled every cycle
        wr(O_VAL, 16'h0A5C, 2'b11);
        bcyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rd(O_STAT, d);
            if (d[0]) begin
                bcyc++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            @(negedge mclk);
        end
        chk("single_busy_cycles", bcyc, 34);
        wait_frames(0, "single");
        chk("single_nframes", cap.size(), 32'h1);
        chk("single_frame", {16'h0, cap[cap.size()-1]}, 32'h0A5C);
        chk("single_vout", {20'h0, vout}, 32'hA5C);
        chk("single_low", last_low, 32);

        // Divider
        wr(O_CTL, 16'h0300, 2'b11);
        wr(O_VAL, 16'h07FF, 2'b11);
        wait_frames(1, "div");
        chk("div_frame", {16'h0, cap[cap.size()-1]}, 32'h07FF);
        chk("div_vout", {20'h0, vout}, 32'h7FF);
        chk("div_low", last_low, 128);
        chk("div_half", last_shi, 4);

        // PD via low-byte write, CLKDIV kept
        wr(O_CTL, 16'h0100, 2'b11);
        wr(O_CTL, 16'hFF02, 2'b01);
        @(negedge mclk);
        rd(O_CTL, d); chk("byte_ctl", {16'h0, d}, 32'h0102);
        wr(O_VAL, 16'hFABC, 2'b11);
        rd(O_VAL, d); chk("byte_val_nibble", {16'h0, d}, 32'h0ABC);
        wait_frames(1, "pd");
        chk("pd_frame", {16'h0, cap[cap.size()-1]}, 32'h2ABC);
        chk("pd_low", last_low, 64);
        repeat (20) @(negedge mclk);

        // Queue overwrite during a frame
        wr(O_CTL, 16'h0000, 2'b11);
        base = cap.size();
        wr(O_VAL, 16'h0111, 2'b11);
        for (int i = 0; i < 200 && nb < 2; i++) @(negedge mclk);
        wr(O_VAL, 16'h0222, 2'b11);
        wr(O_VAL, 16'h0333, 2'b01);
        wr(O_VAL, 16'h0333, 2'b10);
        wait_frames(2, "queue");
        chk("queue_first", {16'h0, cap[base]}, 32'h0111);
        chk("queue_second", {16'h0, cap[base+1]}, 32'h0333);
        chk("queue_gap", last_gap, 2);
        repeat (200) @(negedge mclk);
        chk("queue_no_extra", cap.size(), base + 2);

        // Write on the exact sclk rise that starts a queued frame
        base = cap.size();
        @(negedge mclk);
        for (int i = 0; i < 4 && sclk !== 1'b1; i++) @(negedge mclk);
        wr_at(O_VAL, 16'h0456, 2'b11);
        wr_at(O_VAL, 16'h0789, 2'b11);
        rd(O_STAT, d); chk("simul_stat", {16'h0, d}, 32'h0003);
        wait_frames(2, "simul");
        chk("simul_first", {16'h0, cap[base]}, 32'h0456);
        chk("simul_second", {16'h0, cap[base+1]}, 32'h0789);
        chk("simul_gap", last_gap, 2);

        // Randomized PD / CLKDIV / code
        for (int k = 0; k < 6; k++) begin
            cd = 8'($urandom_range(0, 2));
            pd = 2'($urandom_range(0, 3));
            v  = 12'($urandom_range(0, 4095));
            wr(O_CTL, {cd, 6'h00, pd}, 2'b11);
            wr(O_VAL, {4'($urandom), v}, 2'b11);
            wait_frames(1, "rand");
            chk("rand_frame", {16'h0, cap[cap.size()-1]},
                {16'h0, 2'b00, pd, v});
            chk("rand_low", last_low, 32 * (int'(cd) + 1));
            chk("rand_vout", {20'h0, vout}, {20'h0, v});
        end

        repeat (100) @(negedge mclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
